ahb_lite_bus_matrix_dec: RTL and testbench

Single-master AHB-Lite address decoder and slave response multiplexer for the Cortex-M0 subsystem. It sits between the core's AHB-Lite master port and three slaves: ROM, RAM and peripheral. It replaces the tied-off HSEL/HREADY in the top level. It contains a built-in default slave that returns a two-cycle ERROR response for unmapped NONSEQ/SEQ transfers, plus a saturating decode-error counter for debug.

---
 rtl/ahb_lite_bus_matrix_dec.sv | 149 ++++++++++++++
 tb/tb_ahb_lite_bus_matrix_dec.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahb_lite_bus_matrix_dec.sv
// Single-master AHB-Lite address decoder and slave response multiplexer for ROM, RAM and peripheral slaves.
// An internal default slave answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR and counts them.
module ahb_lite_bus_matrix_dec #(
   parameter logic [15:0] S0_BASE = 16'h0000,
   parameter logic [15:0] S1_BASE = 16'h2000,
   parameter logic [15:0] S2_BASE = 16'h4000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   output logic        HSEL_S0,
   output logic        HSEL_S1,
   output logic        HSEL_S2,
   input  logic [31:0] HRDATA_S0,
   input  logic [31:0] HRDATA_S1,
   input  logic [31:0] HRDATA_S2,
   input  logic        HREADYOUT_S0,
   input  logic        HREADYOUT_S1,
   input  logic        HREADYOUT_S2,
   input  logic        HRESP_S0,
   input  logic        HRESP_S1,
   input  logic        HRESP_S2,
   output logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic [7:0]  ERR_COUNT
);

   localparam int unsigned SEL_W  = 2;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;

   localparam logic [SEL_W-1:0] SEL_S0  = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_S1  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_S2  = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_DEF = SEL_W'(3);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } state_t;

   logic [SEL_W-1:0] decode_c;
   logic [SEL_W-1:0] dsel;
   state_t           state;
   logic             def_ready;
   logic             def_resp;
   logic [CNT_W-1:0] err_count;
   logic             err_start_c;
   logic             unused_bits;

   // Address-phase decode; lower matching slave index wins on overlapping bases.
   always_comb begin
      decode_c = SEL_DEF;
      if (HADDR[31:16] == S0_BASE)      decode_c = SEL_S0;
      else if (HADDR[31:16] == S1_BASE) decode_c = SEL_S1;
      else if (HADDR[31:16] == S2_BASE) decode_c = SEL_S2;
   end

   assign HSEL_S0 = (decode_c == SEL_S0);
   assign HSEL_S1 = (decode_c == SEL_S1);
   assign HSEL_S2 = (decode_c == SEL_S2);

   // Data-phase select follows each accepted address phase and holds through wait states.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel <= SEL_DEF;
      end else if (HREADY) begin
         dsel <= decode_c;
      end
   end

   assign err_start_c = HREADY && (decode_c == SEL_DEF) && HTRANS[1];

   // Default slave: ready/resp are registered decodes of the next state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         def_ready <= 1'b1;
         def_resp  <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE, ERR2: begin
               if (err_start_c) begin
                  state     <= ERR1;
                  def_ready <= 1'b0;
                  def_resp  <= 1'b1;
                  if (err_count != CNT_MAX) begin
                     err_count <= err_count + CNT_W'(1);
                  end
               end else begin
                  state     <= IDLE;
                  def_ready <= 1'b1;
                  def_resp  <= 1'b0;
               end
            end
            ERR1: begin
               state     <= ERR2;
               def_ready <= 1'b1;
               def_resp  <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               def_ready <= 1'b1;
               def_resp  <= 1'b0;
            end
         endcase
      end
   end

   // Response mux driven by the data-phase owner.
   always_comb begin
      HREADY = def_ready;
      HRESP  = def_resp;
      HRDATA = '0;
      case (dsel)
         SEL_S0: begin
            HREADY = HREADYOUT_S0;
            HRESP  = HRESP_S0;
            HRDATA = HRDATA_S0;
         end
         SEL_S1: begin
            HREADY = HREADYOUT_S1;
            HRESP  = HRESP_S1;
            HRDATA = HRDATA_S1;
         end
         SEL_S2: begin
            HREADY = HREADYOUT_S2;
            HRESP  = HRESP_S2;
            HRDATA = HRDATA_S2;
         end
         default: begin
            HREADY = def_ready;
            HRESP  = def_resp;
            HRDATA = DATA_W'(0);
         end
      endcase
   end

   assign ERR_COUNT = err_count;

   // Address offset bits and HTRANS[0] play no part in decode.
   assign unused_bits = ^{HADDR[15:0], HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_bus_matrix_dec.sv
// Directed bench for ahb_lite_bus_matrix_dec: driver pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ahb_lite_bus_matrix_dec;

   typedef struct {
      logic [2:0]  hsel;
      logic        ready;
      logic        resp;
      logic [31:0] rdata;
      logic [7:0]  cnt;
      string       name;
   } exp_t;

   logic        HCLK;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HSEL_S0, HSEL_S1, HSEL_S2;
   logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2;
   logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2;
   logic        HRESP_S0, HRESP_S1, HRESP_S2;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic [7:0]  ERR_COUNT;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;
   int   n_pushed;
   int   n_popped;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [31:0] D0 = 32'hDEADBEEF;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'h2222_2222;
   localparam logic [31:0] A_ROM = 32'h0000_0010;
   localparam logic [31:0] A_RAM = 32'h2000_0004;
   localparam logic [31:0] A_PER = 32'h4000_0000;
   localparam logic [31:0] A_UNM = 32'h1000_0000;
   localparam logic [31:0] A_OFF = 32'hF000_0000;

   ahb_lite_bus_matrix_dec dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2),
      .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2),
      .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1), .HREADYOUT_S2(HREADYOUT_S2),
      .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .ERR_COUNT(ERR_COUNT)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%h required=%h @%0t", nm, field, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge HCLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_popped++;
         chk(e.name, "hsel",  32'({HSEL_S2, HSEL_S1, HSEL_S0}), 32'(e.hsel));
         chk(e.name, "ready", 32'(HREADY), 32'(e.ready));
         chk(e.name, "resp",  32'(HRESP), 32'(e.resp));
         chk(e.name, "rdata", HRDATA, e.rdata);
         chk(e.name, "count", 32'(ERR_COUNT), 32'(e.cnt));
      end
   end

   // One bus cycle: drive inputs just after the rising edge, queue what the cycle must show.
   task automatic step(input logic rst, input logic [31:0] a, input logic [1:0] t, input logic [2:0] rdy,
                       input logic [2:0] hsel_e, input logic ready_e, input logic resp_e,
                       input logic [31:0] d_e, input logic [7:0] c_e, input string nm);
      exp_t e;
      HRESETn      = rst;
      HADDR        = a;
      HTRANS       = t;
      HREADYOUT_S0 = rdy[0];
      HREADYOUT_S1 = rdy[1];
      HREADYOUT_S2 = rdy[2];
      e.hsel  = hsel_e;
      e.ready = ready_e;
      e.resp  = resp_e;
      e.rdata = d_e;
      e.cnt   = c_e;
      e.name  = nm;
      exp_q.push_back(e);
      n_pushed++;
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      int c;
      n_checks = 0; n_fail = 0; n_pushed = 0; n_popped = 0;
      HRESETn = 1'b0; HADDR = A_OFF; HTRANS = T_IDLE;
      HRDATA_S0 = D0; HRDATA_S1 = D1; HRDATA_S2 = D2;
      HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1;
      HRESP_S0 = 1'b0; HRESP_S1 = 1'b0; HRESP_S2 = 1'b0;
      @(posedge HCLK); #1;

      step(1'b0, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd0, "reset");
      // ROM read, zero wait
      step(1'b1, A_ROM, T_NONSEQ, 3'b111, 3'b001, 1'b1, 1'b0, 32'h0, 8'd0, "rom_addr");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, D0,    8'd0, "rom_data");
      // RAM with three wait states while the next address points at peripherals
      step(1'b1, A_RAM, T_NONSEQ, 3'b111, 3'b010, 1'b1, 1'b0, 32'h0, 8'd0, "ram_addr");
      step(1'b1, A_PER, T_NONSEQ, 3'b101, 3'b100, 1'b0, 1'b0, D1,    8'd0, "ram_wait1");
      step(1'b1, A_PER, T_NONSEQ, 3'b101, 3'b100, 1'b0, 1'b0, D1,    8'd0, "ram_wait2");
      step(1'b1, A_PER, T_NONSEQ, 3'b101, 3'b100, 1'b0, 1'b0, D1,    8'd0, "ram_wait3");
      step(1'b1, A_PER, T_NONSEQ, 3'b111, 3'b100, 1'b1, 1'b0, D1,    8'd0, "ram_done");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, D2,    8'd0, "per_data");
      // Unmapped NONSEQ: two-cycle ERROR
      step(1'b1, A_UNM, T_NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd0, "unm_addr");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b0, 1'b1, 32'h0, 8'd1, "unm_err1");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b1, 32'h0, 8'd1, "unm_err2");
      step(1'b1, A_ROM, T_NONSEQ, 3'b111, 3'b001, 1'b1, 1'b0, 32'h0, 8'd1, "after_err");
      // IDLE transfers to an unmapped address get OKAY without waiting
      step(1'b1, A_UNM, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, D0,    8'd1, "idle_unm1");
      step(1'b1, A_UNM, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd1, "idle_unm2");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd1, "idle_unm3");
      // Back-to-back errors, count saturates at 255
      step(1'b1, A_UNM, T_NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd1, "b2b_start");
      for (int k = 0; k < 300; k++) begin
         c = (2 + k > 255) ? 255 : 2 + k;
         step(1'b1, A_UNM, T_NONSEQ, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0, 8'(c), "b2b_err1");
         step(1'b1, A_UNM, T_NONSEQ, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0, 8'(c), "b2b_err2");
      end
      // Now in ERR1 with count 255: reset drops mid-cycle, outputs must clear before any edge
      step(1'b0, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0, 8'd0, "rst_in_err1");
      step(1'b1, A_ROM, T_NONSEQ, 3'b111, 3'b001, 1'b1, 1'b0, 32'h0, 8'd0, "post_rst_addr");
      step(1'b1, A_OFF, T_IDLE,   3'b111, 3'b000, 1'b1, 1'b0, D0,    8'd0, "post_rst_data");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge HCLK);
      #1;
      chk("drain", "popped", 32'(n_popped), 32'(n_pushed));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
